// File: rtl/bcd_event_counter_pkg.sv
// Shared constants for the BCD event counter: digit limit and legal MODULUS range.
package bcd_event_counter_pkg;

  localparam logic [3:0] BCD_MAX     = 4'd9;
  localparam int         MODULUS_MIN = 2;
  localparam int         MODULUS_MAX = 100;

  function automatic logic digit_legal(input logic [3:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_event_counter_digit.sv
// Single BCD digit cell: synchronous clear, parallel load, increment with wrap-out at 9.
module bcd_digit
  import bcd_event_counter_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] ld_val,
  input  logic       inc,
  output logic [3:0] q,
  output logic       wrap
);

  assign wrap = inc & (q == BCD_MAX);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= ld_val;
    end else if (inc) begin
      q <= (q == BCD_MAX) ? '0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/bcd_event_counter.sv
// Two-digit BCD mod-N counter of rising RCO_IN edges, with load check, TC, CARRY, OVF and LDERR.
module bcd_event_counter
  import bcd_event_counter_pkg::*;
#(
  parameter int MODULUS = 60
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       RCO_IN,
  input  logic       EN,
  input  logic       LOAD,
  input  logic [3:0] LD_TENS,
  input  logic [3:0] LD_ONES,
  output logic [3:0] ONES,
  output logic [3:0] TENS,
  output logic       TC,
  output logic       CARRY,
  output logic       OVF,
  output logic       LDERR
);

  localparam logic [3:0] TOP_TENS = 4'((MODULUS - 1) / 10);
  localparam logic [3:0] TOP_ONES = 4'((MODULUS - 1) % 10);
  localparam logic [7:0] MOD_BIN  = 8'(MODULUS);

  logic       rco_q;
  logic       pulse;
  logic       cnt;
  logic       illegal;
  logic       ld_ok;
  logic       digit_clr;
  logic       digit_load;
  logic       ones_wrap;
  logic       tens_wrap;
  logic [7:0] ld_bin;

  assign pulse   = RCO_IN & ~rco_q;
  assign cnt     = EN & pulse & ~LOAD;
  assign TC      = (TENS == TOP_TENS) && (ONES == TOP_ONES);
  assign illegal = ~digit_legal(ONES) | ~digit_legal(TENS);

  assign ld_bin = 8'(LD_TENS) * 8'd10 + 8'(LD_ONES);
  assign ld_ok  = digit_legal(LD_TENS) && digit_legal(LD_ONES) && (ld_bin < MOD_BIN);

  // Wrap at the terminal value and recovery from an illegal digit both reuse the
  // digit clear; the tens wrap-out only fires at 99, where 00 is the right result too.
  assign digit_clr  = CLR | (cnt & (TC | illegal)) | tens_wrap;
  assign digit_load = LOAD & ld_ok;

  bcd_digit u_ones (
    .clk    (CLK),
    .clr    (digit_clr),
    .load   (digit_load),
    .ld_val (LD_ONES),
    .inc    (cnt),
    .q      (ONES),
    .wrap   (ones_wrap)
  );

  bcd_digit u_tens (
    .clk    (CLK),
    .clr    (digit_clr),
    .load   (digit_load),
    .ld_val (LD_TENS),
    .inc    (ones_wrap),
    .q      (TENS),
    .wrap   (tens_wrap)
  );

  always_ff @(posedge CLK) begin
    if (CLR) begin
      rco_q <= 1'b0;
      CARRY <= 1'b0;
      OVF   <= 1'b0;
      LDERR <= 1'b0;
    end else begin
      rco_q <= RCO_IN;
      CARRY <= cnt & TC;
      LDERR <= LOAD & ~ld_ok;
      if (digit_load) begin
        OVF <= 1'b0;
      end else if (cnt & TC) begin
        OVF <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_event_counter.sv
// Directed bench for bcd_event_counter: per-cycle compare against an integer model plus literal pins.
module tb_bcd_event_counter;

  localparam int MODULUS = 60;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic       RCO_IN = 1'b0;
  logic       EN = 1'b0;
  logic       LOAD = 1'b0;
  logic [3:0] LD_TENS = '0;
  logic [3:0] LD_ONES = '0;
  logic [3:0] ONES;
  logic [3:0] TENS;
  logic       TC;
  logic       CARRY;
  logic       OVF;
  logic       LDERR;

  int total = 0;
  int bad = 0;
  bit checking = 1'b0;

  // Model state: count as a plain integer, previous RCO_IN sample, flags.
  int m_val = 0;
  bit m_prev = 1'b0;
  bit m_ovf = 1'b0;
  bit m_carry = 1'b0;
  bit m_lderr = 1'b0;

  bcd_event_counter #(.MODULUS(MODULUS)) dut (
    .CLK     (CLK),
    .CLR     (CLR),
    .RCO_IN  (RCO_IN),
    .EN      (EN),
    .LOAD    (LOAD),
    .LD_TENS (LD_TENS),
    .LD_ONES (LD_ONES),
    .ONES    (ONES),
    .TENS    (TENS),
    .TC      (TC),
    .CARRY   (CARRY),
    .OVF     (OVF),
    .LDERR   (LDERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge CLK) begin
    bit pulse;
    int ld;
    if (CLR) begin
      m_val = 0; m_prev = 0; m_ovf = 0; m_carry = 0; m_lderr = 0;
    end else begin
      pulse = RCO_IN && !m_prev;
      m_prev = RCO_IN;
      m_carry = 0;
      m_lderr = 0;
      ld = 10 * int'(LD_TENS) + int'(LD_ONES);
      if (LOAD) begin
        if (LD_TENS <= 9 && LD_ONES <= 9 && ld < MODULUS) begin
          m_val = ld;
          m_ovf = 0;
        end else begin
          m_lderr = 1;
        end
      end else if (EN && pulse) begin
        if (m_val == MODULUS - 1) begin
          m_val = 0; m_carry = 1; m_ovf = 1;
        end else begin
          m_val = m_val + 1;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (checking) begin
      chk("model_ones",  int'(ONES),  m_val % 10);
      chk("model_tens",  int'(TENS),  m_val / 10);
      chk("model_tc",    int'(TC),    int'(m_val == MODULUS - 1));
      chk("model_carry", int'(CARRY), int'(m_carry));
      chk("model_ovf",   int'(OVF),   int'(m_ovf));
      chk("model_lderr", int'(LDERR), int'(m_lderr));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse_once();
    RCO_IN = 1'b1; cyc(1);
    RCO_IN = 1'b0; cyc(1);
  endtask

  task automatic expect_val(input string name, input int tens, input int ones);
    chk({name, "_tens"}, int'(TENS), tens);
    chk({name, "_ones"}, int'(ONES), ones);
  endtask

  initial begin
    // 1: reset
    cyc(2);
    checking = 1'b1;
    expect_val("reset", 0, 0);
    chk("reset_ovf", int'(OVF), 0);
    chk("reset_carry", int'(CARRY), 0);
    chk("reset_tc", int'(TC), 0);
    CLR = 1'b0;

    // 2: twelve pulses, then a long-held high level counts once
    EN = 1'b1;
    for (int i = 0; i < 12; i++) pulse_once();
    expect_val("twelve", 1, 2);
    RCO_IN = 1'b1; cyc(5);
    RCO_IN = 1'b0; cyc(1);
    expect_val("held", 1, 3);

    // 3: load 58, count to 59 and wrap
    LOAD = 1'b1; LD_TENS = 4'd5; LD_ONES = 4'd8; cyc(1);
    LOAD = 1'b0;
    expect_val("load58", 5, 8);
    RCO_IN = 1'b1; cyc(1);
    expect_val("at59", 5, 9);
    chk("tc59", int'(TC), 1);
    RCO_IN = 1'b0; cyc(1);
    RCO_IN = 1'b1; cyc(1);
    expect_val("wrap", 0, 0);
    chk("wrap_carry", int'(CARRY), 1);
    chk("wrap_ovf", int'(OVF), 1);
    RCO_IN = 1'b0; cyc(1);
    chk("carry_drop", int'(CARRY), 0);
    chk("ovf_sticky", int'(OVF), 1);

    // 4: rejected loads, then an accepted load that swallows a pulse
    LOAD = 1'b1; LD_TENS = 4'd6; LD_ONES = 4'd0; cyc(1);
    chk("lderr60", int'(LDERR), 1);
    expect_val("rej60", 0, 0);
    LD_TENS = 4'd1; LD_ONES = 4'hA; cyc(1);
    chk("lderr1a", int'(LDERR), 1);
    chk("rej_ovf", int'(OVF), 1);
    LD_TENS = 4'd3; LD_ONES = 4'd3; RCO_IN = 1'b1; cyc(1);
    LOAD = 1'b0; RCO_IN = 1'b0;
    expect_val("load33", 3, 3);
    chk("load33_ovf", int'(OVF), 0);
    chk("load33_lderr", int'(LDERR), 0);
    cyc(1);

    // 5: edge while disabled is lost
    EN = 1'b0; RCO_IN = 1'b1; cyc(1);
    EN = 1'b1; cyc(2);
    expect_val("lost_edge", 3, 3);
    RCO_IN = 1'b0; cyc(1);

    // 6: clear from 47 with RCO_IN high, first released cycle counts
    LOAD = 1'b1; LD_TENS = 4'd4; LD_ONES = 4'd7; cyc(1);
    LOAD = 1'b0;
    expect_val("load47", 4, 7);
    RCO_IN = 1'b1; CLR = 1'b1; cyc(1);
    expect_val("clr47", 0, 0);
    CLR = 1'b0; cyc(1);
    expect_val("post_clr", 0, 1);
    RCO_IN = 1'b0; cyc(1);

    // Full lap with varied spacing; model checks every cycle
    for (int i = 0; i < 64; i++) begin
      RCO_IN = 1'b1; cyc(1 + (i % 3));
      RCO_IN = 1'b0; cyc(1 + (i % 2));
    end
    expect_val("lap", 0, 5);
    chk("lap_ovf", int'(OVF), 1);

    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
